// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: decodes the opcode, resolves forwarding, formats the ALU operands
// and holds the result in a single valid/ready slot with load-use stall and flush.
module ex_operand_stage #(
    parameter int WIDTH   = 16,
    parameter int REG_W   = 4,
    parameter int NUM_FWD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              instr,
    input  logic [REG_W-1:0]         rs_idx,
    input  logic [REG_W-1:0]         rt_idx,
    input  logic [WIDTH-1:0]         rs_data,
    input  logic [WIDTH-1:0]         rt_data,
    input  logic [WIDTH-1:0]         pcs,
    input  logic [NUM_FWD-1:0]       fwd_valid,
    input  logic [NUM_FWD-1:0]       fwd_pending,
    input  logic [NUM_FWD*REG_W-1:0] fwd_idx,
    input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [WIDTH-1:0]         store_data,
    output logic [6:0]               alu_op,
    output logic                     hazard
);

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_RED    = 4'h2;
    localparam logic [3:0] OP_XOR    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_PCS    = 4'hE;

    logic [3:0] opcode;
    logic [3:0] imm4;
    logic [7:0] imm8;
    logic       unused_instr_bits;

    assign opcode            = instr[15:12];
    assign imm4              = instr[3:0];
    assign imm8              = instr[7:0];
    assign unused_instr_bits = ^instr[11:8];

    // ---------------------------------------------------------------
    // Operand usage
    // ---------------------------------------------------------------
    logic rs_used;
    logic rt_b_used;
    logic rt_st_used;

    always_comb begin
        rs_used    = (opcode <= OP_LLB);
        rt_b_used  = 1'b0;
        rt_st_used = (opcode == OP_SW);
        case (opcode)
            OP_ADD, OP_SUB, OP_RED, OP_XOR, OP_PADDSB: rt_b_used = 1'b1;
            default:                                   rt_b_used = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------
    // Forwarding match vectors; register 0 never matches
    // ---------------------------------------------------------------
    logic [NUM_FWD-1:0] rs_hit;
    logic [NUM_FWD-1:0] rt_hit;

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd_match
            logic [REG_W-1:0] src_idx;
            assign src_idx    = fwd_idx[gi*REG_W +: REG_W];
            assign rs_hit[gi] = fwd_valid[gi] && (src_idx == rs_idx) && (rs_idx != '0);
            assign rt_hit[gi] = fwd_valid[gi] && (src_idx == rt_idx) && (rt_idx != '0);
        end
    endgenerate

    // Returns {hazarded, value}; scanning downward lets the lowest index win.
    function automatic logic [WIDTH:0] resolve(
        input logic [NUM_FWD-1:0]       hit,
        input logic [NUM_FWD-1:0]       pend,
        input logic [NUM_FWD*WIDTH-1:0] data,
        input logic [WIDTH-1:0]         rf
    );
        logic [WIDTH:0] r;
        r = {1'b0, rf};
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (hit[i]) begin
                r = {pend[i], data[i*WIDTH +: WIDTH]};
            end
        end
        return r;
    endfunction

    logic [WIDTH:0]   rs_res;
    logic [WIDTH:0]   rt_res;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             rs_haz;
    logic             rt_haz;

    assign rs_res = resolve(rs_hit, fwd_pending, fwd_data, rs_data);
    assign rt_res = resolve(rt_hit, fwd_pending, fwd_data, rt_data);
    assign rs_val = rs_res[WIDTH-1:0];
    assign rt_val = rt_res[WIDTH-1:0];
    assign rs_haz = rs_res[WIDTH];
    assign rt_haz = rt_res[WIDTH];

    assign hazard = in_valid & ((rs_used & rs_haz) | ((rt_b_used | rt_st_used) & rt_haz));

    // ---------------------------------------------------------------
    // Operand formatting
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] lhb_a;
    logic [WIDTH-1:0] mem_off;

    generate
        if (WIDTH > 16) begin : g_lhb_wide
            assign lhb_a = {rs_val[WIDTH-1:16], 8'h00, rs_val[7:0]};
        end else begin : g_lhb_16
            assign lhb_a = {8'h00, rs_val[7:0]};
        end
    endgenerate

    assign mem_off = {{(WIDTH-5){imm4[3]}}, imm4, 1'b0};

    logic [WIDTH-1:0] a_fmt;
    logic [WIDTH-1:0] b_fmt;
    logic [WIDTH-1:0] st_fmt;
    logic [6:0]       op_fmt;

    always_comb begin
        a_fmt  = rs_val;
        b_fmt  = '0;
        st_fmt = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_RED, OP_XOR, OP_PADDSB: b_fmt = rt_val;
            OP_SLL, OP_SRA, OP_ROR:                    b_fmt = WIDTH'(imm4);
            OP_LW: begin
                a_fmt = {rs_val[WIDTH-1:1], 1'b0};
                b_fmt = mem_off;
            end
            OP_SW: begin
                a_fmt  = {rs_val[WIDTH-1:1], 1'b0};
                b_fmt  = mem_off;
                st_fmt = rt_val;
            end
            OP_LHB: begin
                a_fmt = lhb_a;
                b_fmt = WIDTH'({imm8, 8'h00});
            end
            OP_LLB: begin
                a_fmt = {rs_val[WIDTH-1:8], 8'h00};
                b_fmt = WIDTH'(imm8);
            end
            OP_PCS: begin
                a_fmt = '0;
                b_fmt = pcs;
            end
            default: ;
        endcase
    end

    // shop is only meaningful to the shifter, so other ops carry zero there.
    logic [1:0] op_sel;
    logic       op_sat;
    logic       op_red;
    logic       op_sub;
    logic [1:0] op_shop;
    logic       is_shift;

    always_comb begin
        is_shift = (opcode == OP_SLL) || (opcode == OP_SRA) || (opcode == OP_ROR);
        op_sel   = 2'b00;
        if (opcode == OP_XOR) begin
            op_sel = 2'b01;
        end else if (is_shift) begin
            op_sel = 2'b10;
        end
        op_sat  = (opcode == OP_PADDSB);
        op_red  = (opcode == OP_RED);
        op_sub  = (opcode == OP_SUB);
        op_shop = is_shift ? opcode[1:0] : 2'b00;
        op_fmt  = {op_sel, op_sat, op_red, op_sub, op_shop};
    end

    // ---------------------------------------------------------------
    // Pipeline slot
    // ---------------------------------------------------------------
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] st_q, st_d;
    logic [6:0]       op_q, op_d;
    logic             accept;

    assign in_ready = (~valid_q | out_ready) & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        st_d    = st_q;
        op_d    = op_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            a_d     = a_fmt;
            b_d     = b_fmt;
            st_d    = st_fmt;
            op_d    = op_fmt;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            st_q    <= '0;
            op_q    <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            st_q    <= st_d;
            op_q    <= op_d;
        end
    end

    assign out_valid  = valid_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign store_data = st_q;
    assign alu_op     = op_q;

endmodule
